// File: rtl/clock_display_scan_pkg.sv
// Shared constants, types and helpers for the HH.MM.SS multiplexed display scanner.
package clock_display_scan_pkg;

    localparam logic [1:0] SELECT_SEC  = 2'd0;
    localparam logic [1:0] SELECT_MIN  = 2'd1;
    localparam logic [1:0] SELECT_HOUR = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [2:0] LAST_DIGIT = 3'd5;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Repeated subtract-and-compare; six passes cover the full 0..63 input range.
    function automatic bcd_t bin_to_bcd(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] tens;
        bcd_t       res;
        rem  = v;
        tens = 4'd0;
        for (int k = 0; k < 6; k++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        res.tens  = tens;
        res.units = rem[3:0];
        return res;
    endfunction

    function automatic logic [5:0] digit_enable(input logic [2:0] idx);
        return ~(6'b000001 << idx);
    endfunction

endpackage

// File: rtl/clock_display_scan_if.sv
// Time-keeper inputs and display-pin outputs of the scanner, grouped as one bundle.
interface clock_display_scan_if;
    logic [5:0] sec_in;
    logic [5:0] min_in;
    logic [4:0] hour_in;
    logic [1:0] select;
    logic       edit_mode;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output sec_in, min_in, hour_in, select, edit_mode,
        input  an, seg, dp
    );

    modport slave (
        input  sec_in, min_in, hour_in, select, edit_mode,
        output an, seg, dp
    );
endinterface

// File: rtl/clock_display_scan_seg7.sv
// BCD digit to active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes are blank.
module seg7_decode
    import clock_display_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Scans a 6-digit HH.MM.SS display one digit per SCAN_DIV cycles from a per-frame time
// snapshot, blanking the selected field on alternate BLINK_DIV-frame phases while editing.
module clock_display_scan
    import clock_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_display_scan_if.slave  disp
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic [2:0]    digit_idx;
    logic          tick;
    logic          frame_wrap;

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [4:0]    snap_hour;

    field_t        field;
    logic [5:0]    field_val;
    logic          field_bad;
    logic          blank;
    bcd_t          bcd;
    logic [3:0]    digit;
    logic [6:0]    seg_raw;
    logic [6:0]    seg_next;
    logic          dp_next;

    logic [5:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    assign tick       = (scan_cnt == SW'(SCAN_DIV - 1));
    assign frame_wrap = tick && (digit_idx == LAST_DIGIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (tick) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == LAST_DIGIT) ? 3'd0 : digit_idx + 3'd1;
        end else begin
            scan_cnt  <= scan_cnt + SW'(1);
        end
    end

    // Loading only at the frame wrap keeps every digit of a frame from one consistent time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_sec  <= 6'd0;
            snap_min  <= 6'd0;
            snap_hour <= 5'd0;
        end else if (frame_wrap) begin
            snap_sec  <= disp.sec_in;
            snap_min  <= disp.min_in;
            snap_hour <= disp.hour_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_wrap) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        field     = FIELD_HOUR;
        field_val = {1'b0, snap_hour};
        case (digit_idx)
            3'd0, 3'd1: begin
                field     = FIELD_SEC;
                field_val = snap_sec;
            end
            3'd2, 3'd3: begin
                field     = FIELD_MIN;
                field_val = snap_min;
            end
            default: begin
                field     = FIELD_HOUR;
                field_val = {1'b0, snap_hour};
            end
        endcase

        field_bad = (field == FIELD_HOUR) ? (field_val >= 6'd24) : (field_val >= 6'd60);

        blank = 1'b0;
        if (disp.edit_mode && blink_off) begin
            case (disp.select)
                SELECT_SEC:  blank = (field == FIELD_SEC);
                SELECT_MIN:  blank = (field == FIELD_MIN);
                SELECT_HOUR: blank = (field == FIELD_HOUR);
                default:     blank = 1'b0;
            endcase
        end

        bcd   = bin_to_bcd(field_val);
        digit = digit_idx[0] ? bcd.tens : bcd.units;

        if (blank)
            seg_next = SEG_BLANK;
        else if (field_bad)
            seg_next = SEG_DASH;
        else
            seg_next = seg_raw;

        dp_next = !((digit_idx == 3'd2) || (digit_idx == 3'd4));
    end

    seg7_decode u_seg7_decode (
        .bcd (digit),
        .seg (seg_raw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q  <= 6'b111111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= digit_enable(digit_idx);
            seg_q <= seg_next;
            dp_q  <= dp_next;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule
